// File: rtl/fdiv_mant_iter.sv
// Radix-2 restoring divider for normalized single-precision mantissas.
// Produces floor(a*2^26/b) over QW cycles, with a sticky bit and divide-by-zero flag.
module fdiv_mant_iter #(
    parameter int QW = 27,
    parameter int MW = 24
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic          cancel,
    input  logic [MW-1:0] a,
    input  logic [MW-1:0] b,
    output logic          busy,
    output logic          stall,
    output logic [4:0]    cnt,
    output logic          done,
    output logic [QW-1:0] q,
    output logic          sticky,
    output logic          dz
);

    typedef enum logic {
        S_IDLE,
        S_ITER
    } state_t;

    localparam logic [4:0] CNT_INIT = 5'(QW);

    state_t        state;
    state_t        state_next;
    logic [MW:0]   r;
    logic [MW-1:0] d;
    logic [MW:0]   r_sub;
    logic [MW:0]   r_next;
    logic          q_bit;
    logic          accept;
    logic          last;

    assign busy   = (state == S_ITER);
    assign stall  = busy;
    assign accept = (state == S_IDLE) && start && !cancel;
    assign last   = (state == S_ITER) && !cancel && (cnt == 5'd1);

    assign r_sub  = r - {1'b0, d};
    assign q_bit  = (r >= {1'b0, d});
    assign r_next = q_bit ? r_sub : r;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_ITER;
            S_ITER: if (cancel || last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With a zero divisor the remainder is held rather than shifted, so it
    // still holds the dividend at the end and sticky reports a != 0.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r      <= '0;
            d      <= '0;
            q      <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            sticky <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                d      <= b;
                r      <= {1'b0, a};
                dz     <= (b == '0);
                cnt    <= CNT_INIT;
                q      <= '0;
                sticky <= 1'b0;
            end else if (state == S_ITER) begin
                if (cancel) begin
                    cnt <= '0;
                end else begin
                    q   <= {q[QW-2:0], q_bit};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        sticky <= (r_next != '0);
                        done   <= 1'b1;
                    end else if (!dz) begin
                        r <= {r_next[MW-1:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fdiv_mant_iter.sv
// Directed, table-driven bench for fdiv_mant_iter with hand-computed quotients
// plus sequences for reset, cancel and start/done handshake corners.
module tb_fdiv_mant_iter;

    logic        clk;
    logic        clrn;
    logic        start;
    logic        cancel;
    logic [23:0] a;
    logic [23:0] b;
    logic        busy;
    logic        stall;
    logic [4:0]  cnt;
    logic        done;
    logic [26:0] q;
    logic        sticky;
    logic        dz;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [26:0] q;
        logic        sticky;
        logic        dz;
    } vec_t;

    vec_t vecs[8];

    fdiv_mant_iter #(.QW(27), .MW(24)) dut (
        .clk(clk), .clrn(clrn), .start(start), .cancel(cancel),
        .a(a), .b(b), .busy(busy), .stall(stall), .cnt(cnt),
        .done(done), .q(q), .sticky(sticky), .dz(dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives a start for one edge; returns #1 after the accepting edge.
    task automatic apply_stimulus(input logic [23:0] va, input logic [23:0] vb);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, tracking cnt/busy/stall each cycle; lat = -1 on timeout.
    task automatic wait_done(output int lat, output bit seq_ok);
        lat    = -1;
        seq_ok = busy && stall && (cnt == 5'd27);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (stall !== busy) seq_ok = 1'b0;
            if (done) begin
                lat = k;
                if (busy || cnt != 5'd0) seq_ok = 1'b0;
                break;
            end
            if (!busy || cnt != 5'(27 - k)) seq_ok = 1'b0;
        end
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        bit seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int lat;
        bit seq_ok;

        vecs[0] = '{24'h800000, 24'h800000, 27'h4000000, 1'b0, 1'b0};
        vecs[1] = '{24'hC00000, 24'h800000, 27'h6000000, 1'b0, 1'b0};
        vecs[2] = '{24'h800000, 24'hC00000, 27'h2AAAAAA, 1'b1, 1'b0};
        vecs[3] = '{24'hFFFFFF, 24'h800000, 27'h7FFFFF8, 1'b0, 1'b0};
        vecs[4] = '{24'h900000, 24'h000000, 27'h7FFFFFF, 1'b1, 1'b1};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 27'h4000000, 1'b0, 1'b0};
        vecs[6] = '{24'h800000, 24'hFFFFFF, 27'h2000002, 1'b1, 1'b0};
        vecs[7] = '{24'h000000, 24'h000000, 27'h7FFFFFF, 1'b0, 1'b1};

        clrn   = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        a      = '0;
        b      = '0;
        @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy},   32'd0);
        check("reset_stall",  {31'd0, stall},  32'd0);
        check("reset_cnt",    {27'd0, cnt},    32'd0);
        check("reset_done",   {31'd0, done},   32'd0);
        check("reset_q",      {5'd0, q},       32'd0);
        check("reset_sticky", {31'd0, sticky}, 32'd0);
        check("reset_dz",     {31'd0, dz},     32'd0);
        @(posedge clk);
        #1;
        clrn = 1'b0;
        @(posedge clk);
        #1;

        // Table of arithmetic vectors, each followed by a one-cycle done check.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b);
            wait_done(lat, seq_ok);
            check($sformatf("vec%0d_latency", i), lat,               32'd27);
            check($sformatf("vec%0d_cnt_seq", i), {31'd0, seq_ok},   32'd1);
            check($sformatf("vec%0d_q", i),       {5'd0, q},         {5'd0, vecs[i].q});
            check($sformatf("vec%0d_sticky", i),  {31'd0, sticky},   {31'd0, vecs[i].sticky});
            check($sformatf("vec%0d_dz", i),      {31'd0, dz},       {31'd0, vecs[i].dz});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_q_hold", i),     {5'd0, q},     {5'd0, vecs[i].q});
        end

        // Asynchronous reset in the middle of iteration 10.
        apply_stimulus(24'h800000, 24'h800000);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        clrn = 1'b1;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_cnt",  {27'd0, cnt},  32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        clrn = 1'b0;
        watch_no_done("midreset_no_done", 40);

        // Start while busy must not disturb the running operation.
        apply_stimulus(24'hC00000, 24'h800000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        apply_stimulus(24'h800000, 24'hC00000);
        wait_done(lat, seq_ok);
        check("busy_start_latency", lat + 6, 32'd27);
        check("busy_start_q",      {5'd0, q},       32'h6000000);
        check("busy_start_sticky", {31'd0, sticky}, 32'd0);
        @(posedge clk);
        #1;

        // Cancel at iteration 5.
        apply_stimulus(24'h800000, 24'h800000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy",  {31'd0, busy},  32'd0);
        check("cancel_stall", {31'd0, stall}, 32'd0);
        check("cancel_cnt",   {27'd0, cnt},   32'd0);
        watch_no_done("cancel_no_done", 35);

        // Cancel together with start in IDLE blocks the launch.
        cancel = 1'b1;
        apply_stimulus(24'h800000, 24'h800000);
        cancel = 1'b0;
        check("cancel_start_busy", {31'd0, busy}, 32'd0);
        watch_no_done("cancel_start_no_done", 35);

        // Back-to-back: new start issued in the done cycle.
        apply_stimulus(24'h800000, 24'h800000);
        wait_done(lat, seq_ok);
        check("b2b_first_latency", lat,       32'd27);
        check("b2b_first_q",       {5'd0, q}, 32'h4000000);
        apply_stimulus(24'hC00000, 24'h800000);
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_done", {31'd0, done}, 32'd0);
        wait_done(lat, seq_ok);
        check("b2b_second_latency", lat,               32'd27);
        check("b2b_second_cnt_seq", {31'd0, seq_ok},   32'd1);
        check("b2b_second_q",       {5'd0, q},         32'h6000000);
        check("b2b_second_sticky",  {31'd0, sticky},   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
